// File: rtl/snake_direction_queue.sv
// rtl/snake_direction_queue.sv - button edge detect, snake turn rules and 2-entry turn FIFO
//
// Purpose: turns debounced button levels into snake turns. New presses are
// validated against the most recent intended direction (queued tail or
// committed direction), rejecting duplicates and 180-degree reversals.
// Accepted turns wait in a 2-entry FIFO until the game-step tick commits them.
//
// Ports:
//   i_Clk        system clock
//   i_Rst_n      asynchronous active-low reset
//   i_Buttons    debounced levels: bit0 up, bit1 down, bit2 left, bit3 right
//   i_Tick       game-step pulse, pops one pending turn
//   o_Direction  committed direction (00 up, 01 down, 10 left, 11 right)
//   o_Turn       registered pulse, o_Direction was just loaded from the FIFO
//   o_Pending    FIFO occupancy 0..2
//   o_Dropped    registered pulse, a valid press was lost to a full FIFO
module snake_direction_queue #(
    parameter logic [1:0] c_INIT_DIR    = 2'b11,
    parameter int         c_QUEUE_DEPTH = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [3:0] i_Buttons,
    input  logic       i_Tick,
    output logic [1:0] o_Direction,
    output logic       o_Turn,
    output logic [1:0] o_Pending,
    output logic       o_Dropped
);

    localparam logic [1:0] c_FULL = 2'(c_QUEUE_DEPTH);

    logic [3:0] prev_q, prev_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] slot0_q, slot0_d;   // head of the FIFO
    logic [1:0] slot1_q, slot1_d;   // second entry, valid when count is 2
    logic [1:0] count_q, count_d;
    logic       turn_q, turn_d;
    logic       dropped_q, dropped_d;

    logic [3:0] press;
    logic       has_cand;
    logic [1:0] cand;
    logic [1:0] tail_dir;
    logic [1:0] ref_dir;
    logic       valid;
    logic       pop;
    logic       push;
    logic [1:0] count_after_pop;

    always_comb begin
        press    = i_Buttons & ~prev_q;
        has_cand = |press;

        // Fixed priority; losing simultaneous presses are simply discarded.
        if (press[0])      cand = 2'b00;
        else if (press[1]) cand = 2'b01;
        else if (press[2]) cand = 2'b10;
        else               cand = 2'b11;

        // Validate against where the snake will be heading once the queue
        // drains, using state from before any pop this cycle.
        tail_dir = (count_q == 2'd2) ? slot1_q : slot0_q;
        ref_dir  = (count_q != 2'd0) ? tail_dir : dir_q;
        valid    = has_cand && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));

        // Pop frees capacity before the push, so a full FIFO can still accept
        // a press on a tick cycle. An empty FIFO never bypasses to dir_q.
        pop             = i_Tick && (count_q != 2'd0);
        count_after_pop = pop ? (count_q - 2'd1) : count_q;
        push            = valid && (count_after_pop != c_FULL);

        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (pop) begin
            slot0_d = slot1_q;
        end
        if (push) begin
            if (count_after_pop == 2'd0) slot0_d = cand;
            else                         slot1_d = cand;
        end

        count_d   = count_after_pop + {1'b0, push};
        dir_d     = pop ? slot0_q : dir_q;
        turn_d    = pop;
        dropped_d = valid && !push;
        prev_d    = i_Buttons;
    end

    // prev resets to all ones so a button held through reset is not a press.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            prev_q    <= 4'b1111;
            dir_q     <= c_INIT_DIR;
            slot0_q   <= 2'b00;
            slot1_q   <= 2'b00;
            count_q   <= 2'd0;
            turn_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            dir_q     <= dir_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            count_q   <= count_d;
            turn_q    <= turn_d;
            dropped_q <= dropped_d;
        end
    end

    assign o_Direction = dir_q;
    assign o_Turn      = turn_q;
    assign o_Pending   = count_q;
    assign o_Dropped   = dropped_q;

endmodule

// File: tb/tb_snake_direction_queue.sv
// tb/tb_snake_direction_queue.sv - self-checking bench for snake_direction_queue
module tb_snake_direction_queue;

    logic       clk;
    logic       rst_n;
    logic [3:0] buttons;
    logic       tick;
    logic [1:0] direction;
    logic       turn;
    logic [1:0] pending;
    logic       dropped;

    int checks = 0;
    int errors = 0;

    snake_direction_queue dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Buttons   (buttons),
        .i_Tick      (tick),
        .o_Direction (direction),
        .o_Turn      (turn),
        .o_Pending   (pending),
        .o_Dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of turns plus the committed direction.
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    logic [3:0] m_prev;
    logic       m_turn;
    logic       m_drop;

    function automatic void model_reset();
        m_q.delete();
        m_dir  = 2'b11;
        m_prev = 4'b1111;
        m_turn = 1'b0;
        m_drop = 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [3:0] pr;
            logic [1:0] c;
            logic [1:0] r;
            logic       ok;
            pr     = buttons & ~m_prev;
            m_prev = buttons;
            ok     = 1'b0;
            c      = 2'b00;
            for (int i = 3; i >= 0; i--) begin
                if (pr[i]) begin
                    c  = 2'(i);
                    ok = 1'b1;
                end
            end
            r = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
            if (c == r || c == (r ^ 2'b01)) ok = 1'b0;
            m_turn = 1'b0;
            m_drop = 1'b0;
            if (tick && m_q.size() > 0) begin
                m_dir  = m_q.pop_front();
                m_turn = 1'b1;
            end
            if (ok) begin
                if (m_q.size() < 2) m_q.push_back(c);
                else                m_drop = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        check("dir_vs_model", int'(direction), int'(m_dir));
        check("pending_vs_model", int'(pending), m_q.size());
        check("turn_vs_model", int'(turn), int'(m_turn));
        check("dropped_vs_model", int'(dropped), int'(m_drop));
    end

    // Apply inputs for one cycle; returns 1 ns after the active edge.
    task automatic step(input logic [3:0] b, input logic t);
        buttons = b;
        tick    = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        rst_n   = 1'b0;
        buttons = 4'b0000;
        tick    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0000, 1'b0);
        check("reset_dir", int'(direction), 3);
        check("reset_pending", int'(pending), 0);

        // Up press, then tick commits it
        step(4'b0001, 1'b0);
        check("up_pending", int'(pending), 1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        check("up_dir", int'(direction), 0);
        check("up_turn", int'(turn), 1);
        check("up_pending0", int'(pending), 0);
        step(4'b0000, 1'b0);
        check("turn_pulse_end", int'(turn), 0);

        // Back to right
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b1);
        check("right_dir", int'(direction), 3);

        // Reversal then duplicate: both ignored silently
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b1000, 1'b0);
        check("dup_dropped", int'(dropped), 0);
        step(4'b0000, 1'b0);
        check("rev_dup_pending", int'(pending), 0);

        // Up then left against queued up: both accepted
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        check("two_pending", int'(pending), 2);
        step(4'b0000, 1'b0);

        // Down while full: dropped for one cycle
        step(4'b0010, 1'b0);
        check("full_dropped", int'(dropped), 1);
        check("full_pending", int'(pending), 2);
        step(4'b0000, 1'b0);
        check("drop_pulse_end", int'(dropped), 0);

        // Down with tick while full: accepted
        step(4'b0010, 1'b1);
        check("tickpush_pending", int'(pending), 2);
        check("tickpush_dropped", int'(dropped), 0);
        check("tickpush_dir", int'(direction), 0);
        step(4'b0000, 1'b1);
        check("drain_dir_left", int'(direction), 2);
        step(4'b0000, 1'b1);
        check("drain_dir_down", int'(direction), 1);
        check("drain_pending", int'(pending), 0);

        // Return to right, then simultaneous up+left
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b1);
        check("right_again", int'(direction), 3);
        step(4'b0101, 1'b0);
        check("simul_pending", int'(pending), 1);
        for (int i = 0; i < 100; i++) step(4'b0101, 1'b0);
        check("hold_pending", int'(pending), 1);
        step(4'b0000, 1'b0);

        // Left onto queued up: full, then async reset mid-cycle
        step(4'b0100, 1'b0);
        check("prereset_pending", int'(pending), 2);
        buttons = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pending", int'(pending), 0);
        check("async_dir", int'(direction), 3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        check("held_through_reset", int'(pending), 0);
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        check("repress_pending", int'(pending), 1);
        step(4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_direction_queue.md
Name: snake_direction_queue

Overview:
Sits directly downstream of the push-button debouncer. Consumes the 4 debounced button levels, detects new presses, and applies snake-game turn rules: no duplicate turns and no 180° reversal. Accepted turns are buffered in a 2-entry FIFO, so two quick presses between game steps are both kept. The game-step logic pops one turn per tick and reads the committed direction.

Parameters:
c_INIT_DIR, 2'b11, direction loaded at reset (00 up, 01 down, 10 left, 11 right)
c_QUEUE_DEPTH, 2, pending-turn FIFO depth (fixed at 2; other values unsupported)

Ports:
i_Clk  input  1  system clock
i_Rst_n  input  1  asynchronous active-low reset
i_Buttons  input  4  debounced button levels; bit0 up, bit1 down, bit2 left, bit3 right
i_Tick  input  1  one-cycle game-step pulse; pops one pending turn
o_Direction  output  2  committed direction (00 up, 01 down, 10 left, 11 right)
o_Turn  output  1  one-cycle pulse when o_Direction was loaded from the FIFO
o_Pending  output  2  FIFO occupancy, 0..2
o_Dropped  output  1  one-cycle pulse when a valid press was lost because the FIFO was full

Behaviour:
- Reset (i_Rst_n low, asynchronous): o_Direction=c_INIT_DIR, FIFO empty, o_Pending=0, o_Turn=0, o_Dropped=0, previous-button register=4'b1111.
- Because the previous-button register resets to all ones, a button held through reset release creates no press until it is released and pressed again.
- Edge detect: press = i_Buttons & ~prev; prev <= i_Buttons every cycle. Only rising edges count. Holding a button never repeats.
- Simultaneous rising edges in one cycle: priority up > down > left > right. Exactly one candidate is taken and the others are discarded (not deferred).
- Reference direction for validation: FIFO tail entry if o_Pending>0, else o_Direction. Evaluated from pre-edge state.
- Candidate rejected silently (no push, no o_Dropped) when:
  - it equals the reference (duplicate), or
  - it equals reference ^ 2'b01 (reversal).
- Valid candidate with o_Pending<2: pushed at the tail; o_Pending increments on the same edge.
- Valid candidate with o_Pending==2: discarded; o_Dropped=1 for the following cycle.
- i_Tick high with o_Pending>0, at that same edge:
  - head is popped into o_Direction;
  - o_Turn=1 for the following cycle;
  - o_Pending decrements.
- i_Tick high with o_Pending==0: no change, o_Turn stays 0.
- Tick and valid press in the same cycle:
  - validation uses the pre-pop reference;
  - the pop is performed first for capacity, so a full FIFO accepts the push (o_Pending stays 2) and o_Dropped stays 0;
  - an empty FIFO never bypasses: the pushed turn is applied on a later tick, and o_Pending goes 0→1.
- Latency: press at cycle N → earliest o_Direction change at the edge of the first tick sampled at cycle ≥N+1.
- FIFO storage: 2×2-bit registers with read/write pointers or a shift structure. Implementation choice, invisible at the ports.
- o_Turn and o_Dropped are registered, never combinational.

Test Plan:
- Reset, then release with i_Buttons=0 → o_Direction=11, o_Pending=0. Press up, then pulse i_Tick → o_Pending 0→1; o_Direction=00 and o_Turn=1 the cycle after the tick.
- With o_Direction=11 (right): press left (reversal), then press right (duplicate) → o_Pending stays 0, o_Dropped never asserted.
- With o_Direction=11, press up then left with no tick (left's reference is queued up, so it is valid) → o_Pending=2. Two ticks → o_Direction 00 then 10.
- With FIFO full (up, left from dir 11): press down → o_Dropped=1 for one cycle, o_Pending stays 2. Repeat the press in the same cycle as i_Tick → accepted, o_Pending stays 2, o_Dropped=0.
- i_Buttons=4'b0101 rising together with dir 11 → only up queued. Button held 100 cycles → exactly one push.
- Assert i_Rst_n low mid-cycle with o_Pending=2 → immediate o_Pending=0, o_Direction=11. Button held across reset release → no push until release and re-press.
